// File: rtl/video_timing_if.sv
// Raster timing bundle driven by the timing generator and consumed by the
// foreground/background pipelines, the object prefetch unit and the CPU IRQ path.
interface video_timing_if;
   logic       hsync_o;
   logic       vsync_o;
   logic       visible_o;
   logic       game_visible_o;
   logic [7:0] display_x_o;
   logic [7:0] display_y_o;
   logic       prefetch_start_o;
   logic [7:0] prefetch_y_o;
   logic       vblank_start_o;

   modport master (
      output hsync_o, vsync_o, visible_o, game_visible_o,
      output display_x_o, display_y_o,
      output prefetch_start_o, prefetch_y_o, vblank_start_o
   );

   modport slave (
      input hsync_o, vsync_o, visible_o, game_visible_o,
      input display_x_o, display_y_o,
      input prefetch_start_o, prefetch_y_o, vblank_start_o
   );
endinterface

// File: rtl/video_timing_prefetch.sv
// Master raster timing: VGA counters, sync/visibility decode, game-space coordinates,
// scanline prefetch requests one display row ahead, and the vblank interrupt pulse.
module video_timing_prefetch #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int H_OFFSET = 64,
   parameter int GAME_W   = 512
) (
   input  logic           gpu_clk,
   input  logic           rst_n,
   video_timing_if.master vid_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_BEG     = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG     = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
   localparam logic [9:0] G_BEG      = 10'(H_OFFSET);
   localparam logic [9:0] G_END      = 10'(H_OFFSET + GAME_W);
   localparam logic [9:0] PF_ROW0_V  = 10'(V_TOTAL - 2);
   // Row r (r>=1) is requested on vcount 2(r-1); the last existing row is V_ACTIVE/2-1.
   localparam logic [9:0] PF_LAST_V  = 10'(V_ACTIVE - 4);

   // Raster position counters
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;

   // Registered outputs
   logic       hsync_q, vsync_q, visible_q, game_visible_q;
   logic [7:0] display_x_q, display_y_q;
   logic       prefetch_start_q;
   logic [7:0] prefetch_y_q;
   logic       vblank_start_q;

   // Decode of the current position, registered on the next edge
   logic       hsync_c, vsync_c, visible_c, game_visible_c;
   logic [9:0] game_x_c;
   logic [7:0] display_x_c, display_y_c;
   logic       pf_hit_c;
   logic [7:0] pf_row_c;
   logic       vblank_c;

   always_comb begin
      h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end
   end

   always_comb begin
      hsync_c        = !((h_q >= HS_BEG) && (h_q < HS_END));
      vsync_c        = !((v_q >= VS_BEG) && (v_q < VS_END));
      visible_c      = (h_q < H_ACT) && (v_q < V_ACT);
      game_visible_c = visible_c && (h_q >= G_BEG) && (h_q < G_END);
      game_x_c       = h_q - G_BEG;
      display_x_c    = 8'(game_x_c >> 1);
      display_y_c    = 8'(v_q >> 1);
      vblank_c       = (h_q == 10'd0) && (v_q == V_ACT);
   end

   // prefetch_start_o is a fire-and-forget request with no ready return: the
   // consumer latches prefetch_y_o on the pulse, and the schedule leaves two full
   // lines between requests so the idle scanline buffer always finishes loading.
   always_comb begin
      pf_hit_c = (h_q == 10'd0) &&
                 ((v_q == PF_ROW0_V) || (!v_q[0] && (v_q <= PF_LAST_V)));
      pf_row_c = (v_q == PF_ROW0_V) ? 8'd0 : 8'(v_q >> 1) + 8'd1;
   end

   always_ff @(posedge gpu_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q              <= 10'd0;
         v_q              <= 10'd0;
         hsync_q          <= 1'b1;
         vsync_q          <= 1'b1;
         visible_q        <= 1'b0;
         game_visible_q   <= 1'b0;
         display_x_q      <= 8'd0;
         display_y_q      <= 8'd0;
         prefetch_start_q <= 1'b0;
         prefetch_y_q     <= 8'd0;
         vblank_start_q   <= 1'b0;
      end else begin
         h_q              <= h_d;
         v_q              <= v_d;
         hsync_q          <= hsync_c;
         vsync_q          <= vsync_c;
         visible_q        <= visible_c;
         game_visible_q   <= game_visible_c;
         prefetch_start_q <= pf_hit_c;
         vblank_start_q   <= vblank_c;
         // Coordinates freeze outside the game window so late consumers see the last pixel
         if (game_visible_c) begin
            display_x_q <= display_x_c;
            display_y_q <= display_y_c;
         end
         if (pf_hit_c) begin
            prefetch_y_q <= pf_row_c;
         end
      end
   end

   assign vid_o.hsync_o          = hsync_q;
   assign vid_o.vsync_o          = vsync_q;
   assign vid_o.visible_o        = visible_q;
   assign vid_o.game_visible_o   = game_visible_q;
   assign vid_o.display_x_o      = display_x_q;
   assign vid_o.display_y_o      = display_y_q;
   assign vid_o.prefetch_start_o = prefetch_start_q;
   assign vid_o.prefetch_y_o     = prefetch_y_q;
   assign vid_o.vblank_start_o   = vblank_start_q;

endmodule
